// File: rtl/inst_cache_sa_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Optional performance counters in the top level are enabled by ICACHE_PERF_EN.
package inst_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned sets, input int unsigned line_words);
        return 30 - idx_width(sets) - off_width(line_words);
    endfunction

    // A one-way cache still needs a 1-bit way pointer to keep vectors legal.
    function automatic int unsigned way_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [31:0] line_mask(input int unsigned off_w);
        return ~((32'd1 << (off_w + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/inst_cache_sa_way.sv
// One cache way: tag, valid and data storage with a combinational read port,
// a beat/tag write port and a global valid clear.
module inst_cache_way
    import inst_cache_pkg::*;
#(
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned WORD_W     = 2,
    parameter int unsigned TAG_W      = 20,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic [31:0]       data_o,
    input  logic              wr_data_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic [31:0]       wr_data_i,
    input  logic              wr_tag_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_set_valid_i,
    input  logic              clear_all_i
);

    localparam int unsigned SETS = 1 << IDX_W;

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];
    logic [SETS-1:0]  valid_q;

    assign valid_o = valid_q[rd_idx_i];
    assign hit_o   = valid_o & (tag_q[rd_idx_i] == rd_tag_i);
    assign data_o  = data_q[rd_idx_i][rd_word_i];

    // Clear has priority so an invalidate on the final beat leaves the line invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (wr_tag_en_i) begin
            valid_q[wr_idx_i] <= wr_set_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_data_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/inst_cache_sa.sv
// Set-associative instruction cache with zero-latency hits and burst line refill.
// Define ICACHE_PERF_EN to add the perf_hits / perf_misses counter outputs.
module inst_cache_sa
    import inst_cache_pkg::*;
#(
    parameter int unsigned SETS       = 256,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        pc_req,
    input  logic        invalidate,
    output logic [31:0] instruction,
    output logic        pc_wait_stop_choke,
    output logic        addr_error,
    output logic        interface_enable,
    output logic [31:0] interface_PC,
    input  logic        interface_valid,
    input  logic [31:0] interface_instruction
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int unsigned OFF_W  = off_width(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_width(SETS);
    localparam int unsigned TAG_W  = tag_width(SETS, LINE_WORDS);
    localparam int unsigned WORD_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned WAY_W  = way_width(WAYS);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              victim_rr_q, victim_rr_d;
    logic              if_en_q, if_en_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic              aligned_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [TAG_W-1:0]  rd_tag_c;
    logic [WORD_W-1:0] rd_word_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [TAG_W-1:0]  wr_tag_c;
    logic [WAYS-1:0]   way_hit;
    logic [WAYS-1:0]   way_valid;
    logic [31:0]       way_data [WAYS];
    logic [31:0]       hit_data_c;
    logic [WAY_W-1:0]  victim_sel_c;
    logic              victim_rr_c;
    logic              lookup_c;
    logic              hit_c;
    logic              miss_c;
    logic              beat_c;
    logic              last_c;
    logic              set_valid_c;

    assign aligned_c = (PC[1:0] == 2'b00);
    assign rd_idx_c  = IDX_W'(PC >> (OFF_W + 2));
    assign rd_tag_c  = TAG_W'(PC >> (IDX_W + OFF_W + 2));
    assign rd_word_c = WORD_W'((PC >> 2) & 32'(LINE_WORDS - 1));

    // The refill target is always derived from the latched line address, never the live PC.
    assign wr_idx_c    = IDX_W'(if_pc_q >> (OFF_W + 2));
    assign wr_tag_c    = TAG_W'(if_pc_q >> (IDX_W + OFF_W + 2));
    assign beat_c      = (state_q == REFILL) & interface_valid;
    assign last_c      = beat_c & (cnt_q == WORD_W'(LINE_WORDS - 1));
    assign set_valid_c = ~(flush_q | invalidate);

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        inst_cache_way #(
            .IDX_W      (IDX_W),
            .WORD_W     (WORD_W),
            .TAG_W      (TAG_W),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk            (clk),
            .reset          (reset),
            .rd_idx_i       (rd_idx_c),
            .rd_tag_i       (rd_tag_c),
            .rd_word_i      (rd_word_c),
            .hit_o          (way_hit[w]),
            .valid_o        (way_valid[w]),
            .data_o         (way_data[w]),
            .wr_data_en_i   (beat_c & (victim_q == WAY_W'(w))),
            .wr_idx_i       (wr_idx_c),
            .wr_word_i      (cnt_q),
            .wr_data_i      (interface_instruction),
            .wr_tag_en_i    (last_c & (victim_q == WAY_W'(w))),
            .wr_tag_i       (wr_tag_c),
            .wr_set_valid_i (set_valid_c),
            .clear_all_i    (invalidate)
        );
    end

    // Way select for hits and victim choice: lowest invalid way, else round-robin.
    always_comb begin
        hit_data_c   = '0;
        victim_sel_c = rr_q[rd_idx_c];
        victim_rr_c  = 1'b1;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (way_hit[w]) begin
                hit_data_c = hit_data_c | way_data[w];
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim_sel_c = WAY_W'(w);
                victim_rr_c  = 1'b0;
            end
        end
    end

    assign lookup_c = (state_q == IDLE) & pc_req & aligned_c;
    assign hit_c    = lookup_c & (|way_hit);
    assign miss_c   = lookup_c & ~(|way_hit);

    assign instruction        = hit_c ? hit_data_c : 32'd0;
    assign pc_wait_stop_choke = (state_q != IDLE) | miss_c;
    assign addr_error         = pc_req & ~aligned_c;
    assign interface_enable   = if_en_q;
    assign interface_PC       = if_pc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        victim_d    = victim_q;
        victim_rr_d = victim_rr_q;
        if_en_d     = if_en_q;
        if_pc_d     = if_pc_q;
        case (state_q)
            IDLE: begin
                if (miss_c) begin
                    state_d     = REFILL;
                    cnt_d       = '0;
                    victim_d    = victim_sel_c;
                    victim_rr_d = victim_rr_c;
                    if_en_d     = 1'b1;
                    if_pc_d     = PC & line_mask(OFF_W);
                end
            end
            REFILL: begin
                if (invalidate) begin
                    flush_d = 1'b1;
                end
                if (beat_c) begin
                    cnt_d = cnt_q + WORD_W'(1);
                end
                if (last_c) begin
                    state_d = DONE;
                    if_en_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                flush_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            if_en_q     <= 1'b0;
            if_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            victim_q    <= victim_d;
            victim_rr_q <= victim_rr_d;
            if_en_q     <= if_en_d;
            if_pc_q     <= if_pc_d;
        end
    end

    // Round-robin only moves when it actually chose the victim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(SETS); s++) begin
                rr_q[s] <= '0;
            end
        end else if (last_c && victim_rr_q) begin
            rr_q[wr_idx_c] <= (rr_q[wr_idx_c] == WAY_W'(WAYS - 1)) ? '0
                                                                  : rr_q[wr_idx_c] + WAY_W'(1);
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_q;
    logic [31:0] perf_misses_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            if (hit_c) begin
                perf_hits_q <= perf_hits_q + 32'd1;
            end
            if (miss_c) begin
                perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_inst_cache_sa.sv
// Directed bench for inst_cache_sa at default parameters (256 sets, 2 ways, 4-word lines).
module tb_inst_cache_sa;

    localparam int unsigned LW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC = 32'd0;
    logic        pc_req = 1'b0;
    logic        invalidate = 1'b0;
    logic [31:0] instruction;
    logic        pc_wait_stop_choke;
    logic        addr_error;
    logic        interface_enable;
    logic [31:0] interface_PC;
    logic        interface_valid = 1'b0;
    logic [31:0] interface_instruction = 32'd0;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_cache_sa dut (
        .clk                   (clk),
        .reset                 (reset),
        .PC                    (PC),
        .pc_req                (pc_req),
        .invalidate            (invalidate),
        .instruction           (instruction),
        .pc_wait_stop_choke    (pc_wait_stop_choke),
        .addr_error            (addr_error),
        .interface_enable      (interface_enable),
        .interface_PC          (interface_PC),
        .interface_valid       (interface_valid),
        .interface_instruction (interface_instruction)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits             (perf_hits),
        .perf_misses           (perf_misses)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        iv;
        logic [31:0] idata;
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_err;
        logic        e_en;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic [31:0] pc, input logic req, input logic iv,
                                input logic [31:0] idata, input logic [31:0] e_instr,
                                input logic e_stall, input logic e_err, input logic e_en,
                                input logic [31:0] e_ipc);
        vec_t v;
        v.pc = pc; v.req = req; v.iv = iv; v.idata = idata; v.e_instr = e_instr;
        v.e_stall = e_stall; v.e_err = e_err; v.e_en = e_en; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a PC that must miss in IDLE, then move into the refill cycle.
    task automatic miss(input logic [31:0] addr, input string tag);
        PC = addr; pc_req = 1'b1; invalidate = 1'b0; interface_valid = 1'b0;
        #1;
        chk({tag, "_miss_stall"}, 32'(pc_wait_stop_choke), 32'd1);
        chk({tag, "_miss_en"}, 32'(interface_enable), 32'd0);
        @(negedge clk);
    endtask

    // Feed one full line of beats, optionally pulsing invalidate on one beat, then pass DONE.
    task automatic beats(input logic [31:0] addr, input logic [31:0] base, input int inv_beat,
                         input string tag);
        int n = 0;
        while (!interface_enable && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_refill_en"}, 32'(interface_enable), 32'd1);
        if (!interface_enable) return;
        chk({tag, "_refill_pc"}, interface_PC, addr & 32'hFFFF_FFF0);
        for (int b = 0; b < int'(LW); b++) begin
            interface_valid = 1'b1;
            interface_instruction = base + 32'(b);
            invalidate = (b == inv_beat);
            #1;
            chk({tag, "_refill_stall"}, 32'(pc_wait_stop_choke), 32'd1);
            @(negedge clk);
        end
        interface_valid = 1'b0;
        invalidate = 1'b0;
        #1;
        chk({tag, "_done_stall"}, 32'(pc_wait_stop_choke), 32'd1);
        chk({tag, "_done_en"}, 32'(interface_enable), 32'd0);
        @(negedge clk);
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        PC = addr; pc_req = 1'b1; invalidate = 1'b0;
        #1;
        chk({tag, "_hit_instr"}, instruction, exp);
        chk({tag, "_hit_stall"}, 32'(pc_wait_stop_choke), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        // Cold miss on 0x1008, 4 beats, DONE, re-lookup, sequential hits, misaligned, idle.
        vecs[0]  = mk(32'h1008, 1, 0, 32'h0,  32'h0,  1, 0, 0, 32'h0);
        vecs[1]  = mk(32'h1008, 1, 1, 32'hA0, 32'h0,  1, 0, 1, 32'h1000);
        vecs[2]  = mk(32'h1008, 1, 1, 32'hA1, 32'h0,  1, 0, 1, 32'h1000);
        vecs[3]  = mk(32'h1008, 1, 1, 32'hA2, 32'h0,  1, 0, 1, 32'h1000);
        vecs[4]  = mk(32'h1008, 1, 1, 32'hA3, 32'h0,  1, 0, 1, 32'h1000);
        vecs[5]  = mk(32'h1008, 1, 0, 32'h0,  32'h0,  1, 0, 0, 32'h1000);
        vecs[6]  = mk(32'h1008, 1, 0, 32'h0,  32'hA2, 0, 0, 0, 32'h1000);
        vecs[7]  = mk(32'h1000, 1, 0, 32'h0,  32'hA0, 0, 0, 0, 32'h1000);
        vecs[8]  = mk(32'h1004, 1, 0, 32'h0,  32'hA1, 0, 0, 0, 32'h1000);
        vecs[9]  = mk(32'h1008, 1, 0, 32'h0,  32'hA2, 0, 0, 0, 32'h1000);
        vecs[10] = mk(32'h100C, 1, 0, 32'h0,  32'hA3, 0, 0, 0, 32'h1000);
        vecs[11] = mk(32'h1002, 1, 0, 32'h0,  32'h0,  0, 1, 0, 32'h1000);
        vecs[12] = mk(32'h1004, 0, 0, 32'h0,  32'h0,  0, 0, 0, 32'h1000);

        @(negedge clk);
        #1;
        chk("rst_instr", instruction, 32'd0);
        chk("rst_stall", 32'(pc_wait_stop_choke), 32'd0);
        chk("rst_err", 32'(addr_error), 32'd0);
        chk("rst_en", 32'(interface_enable), 32'd0);
        chk("rst_ipc", interface_PC, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            PC = vecs[i].pc;
            pc_req = vecs[i].req;
            interface_valid = vecs[i].iv;
            interface_instruction = vecs[i].idata;
            #1;
            chk($sformatf("vec%0d_instr", i), instruction, vecs[i].e_instr);
            chk($sformatf("vec%0d_stall", i), 32'(pc_wait_stop_choke), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_err", i), 32'(addr_error), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_en", i), 32'(interface_enable), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_ipc", i), interface_PC, vecs[i].e_ipc);
            @(negedge clk);
        end
        interface_valid = 1'b0;

        // Invalidate together with a hit: the hit is served, then the line is gone.
        PC = 32'h1000; pc_req = 1'b1; invalidate = 1'b1;
        #1;
        chk("invhit_instr", instruction, 32'hA0);
        chk("invhit_stall", 32'(pc_wait_stop_choke), 32'd0);
        @(negedge clk);
        invalidate = 1'b0;
        miss(32'h1000, "inv");

        // Reset in the middle of a refill drops the request asynchronously.
        interface_valid = 1'b1; interface_instruction = 32'hA0;
        @(negedge clk);
        interface_instruction = 32'hA1;
        @(negedge clk);
        interface_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_en", 32'(interface_enable), 32'd0);
        chk("midrst_ipc", interface_PC, 32'd0);
        pc_req = 1'b0;
        #1;
        chk("midrst_stall", 32'(pc_wait_stop_choke), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        miss(32'h1000, "postrst");
        beats(32'h1000, 32'hA0, -1, "postrst");
        hit(32'h1008, 32'hA2, "postrst");

        pc_req = 1'b0; invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;

        // Three lines in set 0: the third evicts way 0 via round-robin.
        miss(32'h0000, "s0a");
        beats(32'h0000, 32'hB0, -1, "s0a");
        hit(32'h0000, 32'hB0, "s0a");
        miss(32'h4000, "s0b");
        beats(32'h4000, 32'hC0, -1, "s0b");
        hit(32'h4004, 32'hC1, "s0b");
        hit(32'h0000, 32'hB0, "s0a_keep");
        miss(32'h8000, "s0c");
        beats(32'h8000, 32'hD0, -1, "s0c");
        hit(32'h800C, 32'hD3, "s0c");
        hit(32'h4000, 32'hC0, "s0b_keep");
        miss(32'h0000, "s0a_evict");
        beats(32'h0000, 32'hB0, -1, "s0a_evict");

        // Invalidate during the second beat leaves the new line invalid.
        miss(32'h2000, "flush");
        beats(32'h2000, 32'hE0, 1, "flush");
        miss(32'h2000, "flush_remiss");
        chk("flush_reen", 32'(interface_enable), 32'd1);
        beats(32'h2000, 32'hE0, -1, "flush_refill");
        hit(32'h2004, 32'hE1, "flush");

        pc_req = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
